// File: rtl/perceptron_predictor.sv
// ---------------------------------------------------------------------------
// perceptron_predictor
//
// Perceptron conditional-branch direction predictor for the frontend.
// Each table entry holds GHR_LENGTH+1 signed weights (w0 is the bias). A
// prediction is the dot product of the indexed weight vector with the
// speculative global history (bipolar: history bit 1 -> +w, 0 -> -w),
// registered one cycle after the request. Training comes from execute-stage
// feedback and is threshold-gated with saturating weight updates.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                restore speculative GHR from committed GHR
//   debug_mode_i           freeze training and both history registers
//   req_valid_i, vpc_i     prediction request and branch PC
//   pred_valid_o           one-cycle strobe, one cycle after req_valid_i
//   pred_taken_o           predicted direction (sum >= 0)
//   pred_sum_o             signed perceptron output
//   pred_history_o         speculative GHR used for this prediction
//   upd_valid_i, upd_pc_i  resolved conditional branch and its PC
//   upd_taken_i            actual direction
//   upd_mispredict_i       the earlier prediction was wrong
//   upd_history_i          history snapshot returned with the branch
//   upd_sum_i              perceptron sum returned with the branch
// ---------------------------------------------------------------------------
module perceptron_predictor #(
    parameter int unsigned VLEN         = 64,
    parameter int unsigned GHR_LENGTH   = 16,
    parameter int unsigned NR_ENTRIES   = 256,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned THETA        = 44,
    localparam int unsigned SUM_WIDTH   = WEIGHT_WIDTH + $clog2(GHR_LENGTH + 1) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 debug_mode_i,
    input  logic                 req_valid_i,
    input  logic [VLEN-1:0]      vpc_i,
    output logic                 pred_valid_o,
    output logic                 pred_taken_o,
    output logic [SUM_WIDTH-1:0] pred_sum_o,
    output logic [GHR_LENGTH-1:0] pred_history_o,
    input  logic                 upd_valid_i,
    input  logic [VLEN-1:0]      upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispredict_i,
    input  logic [GHR_LENGTH-1:0] upd_history_i,
    input  logic [SUM_WIDTH-1:0] upd_sum_i
);

    localparam int H     = GHR_LENGTH;
    localparam int W     = WEIGHT_WIDTH;
    localparam int NR    = NR_ENTRIES;
    localparam int IDX_W = $clog2(NR_ENTRIES);

    localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [SUM_WIDTH:0]  THETA_EXT = (SUM_WIDTH + 1)'(THETA);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic signed [W-1:0] weight_q [NR][H+1];
    logic signed [W-1:0] weight_d [H+1];

    logic [H-1:0] s_ghr_q, s_ghr_d;
    logic [H-1:0] c_ghr_q, c_ghr_d;

    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [SUM_WIDTH-1:0] pred_sum_q, pred_sum_d;
    logic [H-1:0]         pred_history_q, pred_history_d;

    // -----------------------------------------------------------------------
    // Index hash: bit 0 is dropped so compressed-instruction PCs spread out.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;

    assign pred_idx = vpc_i[IDX_W:1];
    assign upd_idx  = upd_pc_i[IDX_W:1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                              upd_pc_i[VLEN-1:IDX_W+1], upd_pc_i[0]};

    // -----------------------------------------------------------------------
    // Prediction: sign-extend every weight to SUM_WIDTH, negate it where the
    // corresponding history bit is 0, then add all terms. The width leaves
    // room for H+1 extreme weights, so the sum cannot overflow.
    // -----------------------------------------------------------------------
    logic signed [SUM_WIDTH-1:0] rd_term [H+1];
    logic signed [SUM_WIDTH-1:0] pred_sum;
    logic                        pred_taken;

    for (genvar gi = 0; gi <= H; gi++) begin : g_term
        logic signed [SUM_WIDTH-1:0] w_ext;
        assign w_ext = {{(SUM_WIDTH-W){weight_q[pred_idx][gi][W-1]}}, weight_q[pred_idx][gi]};
        if (gi == 0) begin : g_bias
            assign rd_term[gi] = w_ext;
        end else begin : g_hist
            assign rd_term[gi] = s_ghr_q[gi-1] ? w_ext : -w_ext;
        end
    end

    always_comb begin
        pred_sum = '0;
        for (int k = 0; k <= H; k++) begin
            pred_sum = pred_sum + rd_term[k];
        end
    end

    assign pred_taken = ~pred_sum[SUM_WIDTH-1];

    // -----------------------------------------------------------------------
    // Training: |upd_sum_i| is taken one bit wider so the most negative sum
    // does not wrap when negated.
    // -----------------------------------------------------------------------
    logic                      upd_active;
    logic                      train_en;
    logic signed [SUM_WIDTH:0] upd_sum_ext;
    logic signed [SUM_WIDTH:0] upd_sum_abs;
    logic                      sum_within_theta;

    assign upd_active       = upd_valid_i && !debug_mode_i;
    assign upd_sum_ext      = {upd_sum_i[SUM_WIDTH-1], upd_sum_i};
    assign upd_sum_abs      = upd_sum_ext[SUM_WIDTH] ? -upd_sum_ext : upd_sum_ext;
    assign sum_within_theta = $unsigned(upd_sum_abs) <= THETA_EXT;
    assign train_en         = upd_active && (upd_mispredict_i || sum_within_theta);

    // Per-weight saturating step: increment when the outcome agrees with the
    // history bit (or is taken, for the bias); a weight at its limit holds.
    for (genvar gi = 0; gi <= H; gi++) begin : g_train
        logic                inc;
        logic signed [W-1:0] cur;

        assign cur = weight_q[upd_idx][gi];

        if (gi == 0) begin : g_bias
            assign inc = upd_taken_i;
        end else begin : g_hist
            assign inc = (upd_taken_i == upd_history_i[gi-1]);
        end

        always_comb begin
            if (inc) begin
                weight_d[gi] = (cur == W_MAX) ? cur : cur + W'(1);
            end else begin
                weight_d[gi] = (cur == W_MIN) ? cur : cur - W'(1);
            end
        end
    end

    // The prediction above reads weight_q before this write lands, so a
    // same-cycle predict/update on one index sees the old weights.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NR; e++) begin
                for (int k = 0; k <= H; k++) begin
                    weight_q[e][k] <= '0;
                end
            end
        end else if (train_en) begin
            for (int k = 0; k <= H; k++) begin
                weight_q[upd_idx][k] <= weight_d[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Global history. Recovery from a mispredict beats a flush, which beats
    // the speculative shift from a prediction made in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        c_ghr_d = c_ghr_q;
        if (upd_active) begin
            c_ghr_d = {c_ghr_q[H-2:0], upd_taken_i};
        end
    end

    always_comb begin
        s_ghr_d = s_ghr_q;
        if (!debug_mode_i) begin
            if (upd_valid_i && upd_mispredict_i) begin
                s_ghr_d = c_ghr_d;
            end else if (flush_i) begin
                s_ghr_d = c_ghr_q;
            end else if (req_valid_i) begin
                s_ghr_d = {s_ghr_q[H-2:0], pred_taken};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Prediction output registers: payload holds between requests.
    // -----------------------------------------------------------------------
    always_comb begin
        pred_valid_d   = req_valid_i;
        pred_taken_d   = pred_taken_q;
        pred_sum_d     = pred_sum_q;
        pred_history_d = pred_history_q;
        if (req_valid_i) begin
            pred_taken_d   = pred_taken;
            pred_sum_d     = pred_sum;
            pred_history_d = s_ghr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_ghr_q        <= '0;
            c_ghr_q        <= '0;
            pred_valid_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_sum_q     <= '0;
            pred_history_q <= '0;
        end else begin
            s_ghr_q        <= s_ghr_d;
            c_ghr_q        <= c_ghr_d;
            pred_valid_q   <= pred_valid_d;
            pred_taken_q   <= pred_taken_d;
            pred_sum_q     <= pred_sum_d;
            pred_history_q <= pred_history_d;
        end
    end

    assign pred_valid_o   = pred_valid_q;
    assign pred_taken_o   = pred_taken_q;
    assign pred_sum_o     = pred_sum_q;
    assign pred_history_o = pred_history_q;

endmodule

// File: tb/tb_perceptron_predictor.sv
// ---------------------------------------------------------------------------
// tb_perceptron_predictor
//
// Self-checking bench for perceptron_predictor. A behavioural model keeps the
// weight table as plain integers, computes predictions with integer
// arithmetic and clamps trained weights to the signed range.
// ---------------------------------------------------------------------------
module tb_perceptron_predictor;

    localparam int H     = 16;
    localparam int NR    = 256;
    localparam int W     = 8;
    localparam int THETA = 44;
    localparam int VLEN  = 64;
    localparam int SW    = W + $clog2(H + 1) + 1;
    localparam int HMASK = (1 << H) - 1;
    localparam int WMAX  = (1 << (W - 1)) - 1;
    localparam int WMIN  = -(1 << (W - 1));

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            debug_mode_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic [VLEN-1:0] vpc_i = '0;
    logic            pred_valid_o;
    logic            pred_taken_o;
    logic [SW-1:0]   pred_sum_o;
    logic [H-1:0]    pred_history_o;
    logic            upd_valid_i = 1'b0;
    logic [VLEN-1:0] upd_pc_i = '0;
    logic            upd_taken_i = 1'b0;
    logic            upd_mispredict_i = 1'b0;
    logic [H-1:0]    upd_history_i = '0;
    logic [SW-1:0]   upd_sum_i = '0;

    perceptron_predictor #(
        .VLEN        (VLEN),
        .GHR_LENGTH  (H),
        .NR_ENTRIES  (NR),
        .WEIGHT_WIDTH(W),
        .THETA       (THETA)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .req_valid_i     (req_valid_i),
        .vpc_i           (vpc_i),
        .pred_valid_o    (pred_valid_o),
        .pred_taken_o    (pred_taken_o),
        .pred_sum_o      (pred_sum_o),
        .pred_history_o  (pred_history_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_mispredict_i(upd_mispredict_i),
        .upd_history_i   (upd_history_i),
        .upd_sum_i       (upd_sum_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_w [NR][H+1];
    int m_sghr;
    int m_cghr;
    bit exp_valid;
    bit exp_taken;
    int exp_sum;
    int exp_hist;

    function automatic int pc_index(input logic [VLEN-1:0] pc);
        return int'((pc >> 1) % NR);
    endfunction

    function automatic int clamp_w(input int v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    function automatic int model_sum(input logic [VLEN-1:0] pc);
        int idx = pc_index(pc);
        int y   = m_w[idx][0];
        for (int i = 1; i <= H; i++) begin
            if (((m_sghr >> (i - 1)) & 1) == 1) y += m_w[idx][i];
            else                                y -= m_w[idx][i];
        end
        return y;
    endfunction

    task automatic model_train(input logic [VLEN-1:0] pc, input bit t, input int hist);
        int idx = pc_index(pc);
        m_w[idx][0] = clamp_w(m_w[idx][0] + (t ? 1 : -1));
        for (int i = 1; i <= H; i++) begin
            if (((hist >> (i - 1)) & 1) == int'(t)) m_w[idx][i] = clamp_w(m_w[idx][i] + 1);
            else                                    m_w[idx][i] = clamp_w(m_w[idx][i] - 1);
        end
    endtask

    task automatic idle_inputs();
        req_valid_i      = 1'b0;
        vpc_i            = '0;
        upd_valid_i      = 1'b0;
        upd_pc_i         = '0;
        upd_taken_i      = 1'b0;
        upd_mispredict_i = 1'b0;
        upd_history_i    = '0;
        upd_sum_i        = '0;
        flush_i          = 1'b0;
        debug_mode_i     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        for (int e = 0; e < NR; e++)
            for (int k = 0; k <= H; k++) m_w[e][k] = 0;
        m_sghr = 0; m_cghr = 0;
        exp_valid = 0; exp_taken = 0; exp_sum = 0; exp_hist = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // One clock cycle of stimulus; the model advances alongside and the
    // expected prediction outputs are left in exp_*. Returns 1 time unit
    // after the active edge.
    task automatic cycle(input bit req, input logic [VLEN-1:0] pc,
                         input bit uv, input logic [VLEN-1:0] upc, input bit ut,
                         input bit um, input int uh, input int us,
                         input bit fl, input bit dbg);
        int y = 0;
        bit tk = 0;
        int nc, ns, a;
        req_valid_i      = req;
        vpc_i            = pc;
        upd_valid_i      = uv;
        upd_pc_i         = upc;
        upd_taken_i      = ut;
        upd_mispredict_i = um;
        upd_history_i    = uh[H-1:0];
        upd_sum_i        = us[SW-1:0];
        flush_i          = fl;
        debug_mode_i     = dbg;

        exp_valid = req;
        if (req) begin
            y = model_sum(pc);
            tk = (y >= 0);
            exp_sum = y; exp_taken = tk; exp_hist = m_sghr;
        end
        nc = m_cghr;
        ns = m_sghr;
        if (!dbg && uv) begin
            nc = ((m_cghr << 1) | int'(ut)) & HMASK;
            a  = (us < 0) ? -us : us;
            if (um || a <= THETA) model_train(upc, ut, uh);
        end
        if (!dbg && uv && um)  ns = nc;
        else if (!dbg && fl)   ns = m_cghr;
        else if (!dbg && req)  ns = ((m_sghr << 1) | int'(tk)) & HMASK;

        @(posedge clk_i);
        #1;
        m_cghr = nc;
        m_sghr = ns;
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        int got;
        do_reset();
        n_cmp++; if (pred_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", pred_valid_o); end
        n_cmp++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %0b want 0", pred_taken_o); end
        n_cmp++; if (pred_sum_o !== '0) begin n_err++; $display("FAIL reset_sum: got %0h want 0", pred_sum_o); end
        n_cmp++; if (pred_history_o !== '0) begin n_err++; $display("FAIL reset_hist: got %0h want 0", pred_history_o); end

        cycle(1, 64'h8000_0000, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (pred_valid_o !== 1'b1) begin n_err++; $display("FAIL first_valid: got %0b want 1", pred_valid_o); end
        n_cmp++; if (got != 0) begin n_err++; $display("FAIL first_sum: got %0d want 0", got); end
        n_cmp++; if (pred_taken_o !== 1'b1) begin n_err++; $display("FAIL first_taken: got %0b want 1", pred_taken_o); end
        n_cmp++; if (pred_history_o !== 16'h0000) begin n_err++; $display("FAIL first_hist: got %0h want 0", pred_history_o); end

        cycle(0, '0, 0, '0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pred_valid_o !== 1'b0) begin n_err++; $display("FAIL valid_one_cycle: got %0b want 0", pred_valid_o); end
        n_cmp++; if (pred_taken_o !== 1'b1) begin n_err++; $display("FAIL taken_hold: got %0b want 1", pred_taken_o); end

        cycle(1, 64'h8000_0000, 0, '0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pred_history_o !== 16'h0001) begin n_err++; $display("FAIL spec_shift: got %0h want 0001", pred_history_o); end
        $display("test_reset done: %0d compared / %0d errors so far", n_cmp, n_err);
    endtask

    task automatic test_training();
        int got;
        do_reset();
        repeat (20) cycle(0, '0, 1, 64'h100, 1, 1, 0, 0, 0, 0);
        repeat (16) cycle(0, '0, 1, 64'h200, 0, 1, 0, 0, 0, 0);
        cycle(1, 64'h100, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != 340) begin n_err++; $display("FAIL train_sum: got %0d want 340", got); end
        n_cmp++; if (got != exp_sum) begin n_err++; $display("FAIL train_sum_model: got %0d want %0d", got, exp_sum); end
        n_cmp++; if (pred_taken_o !== 1'b1) begin n_err++; $display("FAIL train_taken: got %0b want 1", pred_taken_o); end
        n_cmp++; if (pred_history_o !== 16'h0000) begin n_err++; $display("FAIL train_hist: got %0h want 0", pred_history_o); end
        $display("test_training done: sum=%0d", got);
    endtask

    task automatic test_saturation();
        int got, want;
        do_reset();
        repeat (200) cycle(0, '0, 1, 64'h300, 1, 1, 0, 0, 0, 0);
        cycle(1, 64'h300, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != -1921) begin n_err++; $display("FAIL sat_sum: got %0d want -1921", got); end
        n_cmp++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL sat_taken: got %0b want 0", pred_taken_o); end
        n_cmp++; if (pred_history_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hist: got %0h want ffff", pred_history_o); end

        // Confident correct updates must leave the saturated entry alone.
        for (int i = 0; i < 10; i++)
            cycle(0, '0, 1, 64'h300, 1'($urandom_range(0, 1)), 0, int'($urandom_range(0, HMASK)),
                  (i % 2 == 0) ? 50 : -50, 0, 0);
        // Threshold boundary on a fresh entry: 45 skips, -44 and 44 train.
        cycle(0, '0, 1, 64'h302, 1, 0, 0, 45, 0, 0);
        cycle(0, '0, 1, 64'h302, 1, 0, 0, -44, 0, 0);
        cycle(0, '0, 1, 64'h302, 1, 0, 0, 44, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 0, 0, 1, 0);

        cycle(1, 64'h300, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        want = 127;
        for (int i = 0; i < H; i++) want += ((exp_hist >> i) & 1) ? -128 : 128;
        n_cmp++; if (got != want) begin n_err++; $display("FAIL sat_hold_sum: got %0d want %0d", got, want); end
        n_cmp++; if (pred_history_o !== exp_hist[H-1:0]) begin n_err++; $display("FAIL sat_hold_hist: got %0h want %0h", pred_history_o, exp_hist[H-1:0]); end

        cycle(1, 64'h302, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        want = 2;
        for (int i = 0; i < H; i++) want += ((exp_hist >> i) & 1) ? -2 : 2;
        n_cmp++; if (got != want) begin n_err++; $display("FAIL theta_boundary: got %0d want %0d", got, want); end
        n_cmp++; if (got != exp_sum) begin n_err++; $display("FAIL theta_model: got %0d want %0d", got, exp_sum); end
        $display("test_saturation done: boundary sum=%0d", got);
    endtask

    task automatic test_recovery();
        int got;
        do_reset();
        repeat (2) cycle(0, '0, 1, 64'h400, 0, 1, 0, 0, 0, 0);
        cycle(1, 64'h10, 0, '0, 0, 0, 0, 0, 0, 0);
        cycle(1, 64'h10, 0, '0, 0, 0, 0, 0, 0, 0);
        cycle(1, 64'h400, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != -26) begin n_err++; $display("FAIL rec_third_sum: got %0d want -26", got); end
        n_cmp++; if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL rec_third_taken: got %0b want 0", pred_taken_o); end
        n_cmp++; if (pred_history_o !== 16'h0003) begin n_err++; $display("FAIL rec_third_hist: got %0h want 0003", pred_history_o); end

        cycle(1, 64'h10, 1, 64'h500, 1, 1, 6, 0, 0, 0);
        n_cmp++; if (pred_valid_o !== 1'b1) begin n_err++; $display("FAIL rec_coincident_valid: got %0b want 1", pred_valid_o); end
        n_cmp++; if (pred_history_o !== 16'h0006) begin n_err++; $display("FAIL rec_coincident_hist: got %0h want 0006", pred_history_o); end

        cycle(1, 64'h10, 0, '0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pred_history_o !== 16'h0001) begin n_err++; $display("FAIL rec_sghr: got %0h want 0001", pred_history_o); end
        $display("test_recovery done");
    endtask

    task automatic test_flush();
        logic [15:0] pat;
        pat = 16'h00A5;
        do_reset();
        for (int b = H - 1; b >= 0; b--)
            cycle(1, 64'h10, 1, 64'h20, pat[b], 0, 0, 100, 0, 0);
        cycle(1, 64'h10, 0, '0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (pred_history_o !== 16'hFFFF) begin n_err++; $display("FAIL flush_pre_hist: got %0h want ffff", pred_history_o); end
        cycle(1, 64'h10, 0, '0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pred_history_o !== 16'h00A5) begin n_err++; $display("FAIL flush_restore: got %0h want 00a5", pred_history_o); end
        cycle(0, '0, 0, '0, 0, 0, 0, 0, 1, 0);
        cycle(1, 64'h10, 0, '0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (pred_history_o !== 16'h00A5) begin n_err++; $display("FAIL flush_cghr_kept: got %0h want 00a5", pred_history_o); end
        $display("test_flush done");
    endtask

    task automatic test_debug();
        int got, keep_sum;
        int keep_hist;
        do_reset();
        repeat (3) cycle(0, '0, 1, 64'h600, 1, 1, 0, 0, 0, 0);
        cycle(1, 64'h600, 1, 64'h600, 0, 1, 16'h5555, 0, 0, 1);
        got = $signed(pred_sum_o);
        keep_sum = exp_sum;
        keep_hist = exp_hist;
        n_cmp++; if (got != 3 - 3 * 3 + 13 * 3) begin n_err++; $display("FAIL dbg_pred_sum: got %0d want 33", got); end
        n_cmp++; if (pred_history_o !== 16'h0007) begin n_err++; $display("FAIL dbg_pred_hist: got %0h want 0007", pred_history_o); end
        cycle(1, 64'h600, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != keep_sum) begin n_err++; $display("FAIL dbg_table_frozen: got %0d want %0d", got, keep_sum); end
        n_cmp++; if (pred_history_o !== keep_hist[H-1:0]) begin n_err++; $display("FAIL dbg_ghr_frozen: got %0h want %0h", pred_history_o, keep_hist[H-1:0]); end
        $display("test_debug done");
    endtask

    task automatic test_same_index();
        int got;
        do_reset();
        cycle(1, 64'h700, 1, 64'h700, 1, 1, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != 0) begin n_err++; $display("FAIL same_idx_old: got %0d want 0", got); end
        cycle(1, 64'h700, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != 15) begin n_err++; $display("FAIL same_idx_new: got %0d want 15", got); end
        n_cmp++; if (pred_history_o !== 16'h0001) begin n_err++; $display("FAIL same_idx_hist: got %0h want 0001", pred_history_o); end
        $display("test_same_index done");
    endtask

    task automatic test_async_reset();
        int got;
        do_reset();
        repeat (5) cycle(0, '0, 1, 64'h100, 1, 1, 0, 0, 0, 0);
        cycle(1, 64'h100, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != 35) begin n_err++; $display("FAIL pre_reset_sum: got %0d want 35", got); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (pred_valid_o !== 1'b0) begin n_err++; $display("FAIL async_valid: got %0b want 0", pred_valid_o); end
        n_cmp++; if (pred_sum_o !== '0) begin n_err++; $display("FAIL async_sum: got %0h want 0", pred_sum_o); end
        do_reset();
        cycle(1, 64'h100, 0, '0, 0, 0, 0, 0, 0, 0);
        got = $signed(pred_sum_o);
        n_cmp++; if (got != 0) begin n_err++; $display("FAIL async_table_clear: got %0d want 0", got); end
        n_cmp++; if (pred_history_o !== 16'h0000) begin n_err++; $display("FAIL async_ghr_clear: got %0h want 0", pred_history_o); end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic [VLEN-1:0] pcs [6] = '{64'h100, 64'h102, 64'h104, 64'h300, 64'h8000_0000, 64'h1FE};
        int got;
        int start_err = n_err;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 9) < 7, pcs[$urandom_range(0, 5)],
                  1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 2, int'($urandom_range(0, HMASK)),
                  int'($urandom_range(0, 120)) - 60,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
            got = $signed(pred_sum_o);
            n_cmp++;
            if (pred_valid_o !== exp_valid || pred_taken_o !== exp_taken || got != exp_sum ||
                pred_history_o !== exp_hist[H-1:0]) begin
                n_err++;
                $display("FAIL random[%0d]: got v=%0b t=%0b s=%0d h=%0h want v=%0b t=%0b s=%0d h=%0h",
                         n, pred_valid_o, pred_taken_o, got, pred_history_o,
                         exp_valid, exp_taken, exp_sum, exp_hist[H-1:0]);
            end
        end
        $display("test_random done: %0d new errors", n_err - start_err);
    endtask

    initial begin
        test_reset();
        test_training();
        test_saturation();
        test_recovery();
        test_flush();
        test_debug();
        test_same_index();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perceptron_predictor.md
Name: perceptron_predictor

Overview:
Parametrised perceptron conditional-branch predictor for the frontend. It holds a table of per-PC signed weight vectors and maintains speculative and committed global history registers with mispredict recovery. It produces a registered taken/not-taken prediction plus a confidence sum. It is trained from execute-stage feedback using threshold-gated, saturating weight updates.

Parameters:
GHR_LENGTH, 16, history bits used (H); each entry has H+1 weights (w0 = bias)
NR_ENTRIES, 256, perceptron table entries; power of two, >= 2
WEIGHT_WIDTH, 8, signed two's-complement weight width (W)
THETA, 44, training threshold (floor(1.93*H+14) for H=16)
SUM_WIDTH = W + $clog2(H+1) + 1, derived local, signed dot-product width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  frontend flush: restore speculative GHR from committed GHR
debug_mode_i  in  1  when high: no training, no GHR changes
req_valid_i  in  1  prediction request this cycle
vpc_i  in  riscv::VLEN  PC of branch to predict
pred_valid_o  out  1  prediction valid (one cycle after req_valid_i)
pred_taken_o  out  1  predicted direction
pred_sum_o  out  SUM_WIDTH  signed perceptron output y
pred_history_o  out  H  speculative GHR snapshot used for this prediction
upd_valid_i  in  1  resolved conditional branch feedback
upd_pc_i  in  riscv::VLEN  PC of resolved branch
upd_taken_i  in  1  actual outcome
upd_mispredict_i  in  1  prediction was wrong
upd_history_i  in  H  history snapshot returned from pred_history_o
upd_sum_i  in  SUM_WIDTH  sum returned from pred_sum_o

Behaviour:
- Index = pc[$clog2(NR_ENTRIES):1] (bit 0 dropped for compressed instructions); same hash for predict and update.
- Reset: all weights 0, s_ghr = c_ghr = 0, pred_valid_o=0, pred_taken_o=0, pred_sum_o=0, pred_history_o=0.
- Predict (latency 1): in the cycle req_valid_i is high, compute y = w0 + sum over i=1..H of (s_ghr[i-1] ? +wi : -wi), sign-extended to SUM_WIDTH, no overflow possible. Register y, taken = (y >= 0), and the s_ghr value into the outputs; pred_valid_o is high the next cycle only. Outputs hold their values while pred_valid_o is low.
- Speculative shift: on a registered prediction, s_ghr <= {s_ghr[H-2:0], taken}; bit 0 is the most recent outcome.
- Commit: on upd_valid_i, c_ghr <= {c_ghr[H-2:0], upd_taken_i}.
- Recovery: upd_valid_i && upd_mispredict_i sets s_ghr <= the new c_ghr value in the same edge. This takes priority over a same-cycle speculative shift and over flush_i. The coincident prediction output is still produced.
- flush_i without mispredict: s_ghr <= c_ghr (current value); the pending speculative shift is discarded.
- Training: on upd_valid_i when (upd_mispredict_i || |upd_sum_i| <= THETA):
  - w0 += upd_taken_i ? +1 : -1.
  - wi += (upd_taken_i == upd_history_i[i-1]) ? +1 : -1.
  - Saturate at +(2^(W-1)-1) and -(2^(W-1)). A weight at a limit holds.
  - Otherwise the entry is unchanged.
- Read/write to the same index in the same cycle: the prediction uses pre-update weights; the write lands at the edge.
- debug_mode_i high: updates are ignored (no training, no c_ghr/s_ghr change). Predictions are still served and do not shift s_ghr.
- Reset asserted mid-operation: all state clears immediately; pred_valid_o drops asynchronously.

Test Plan:
- Reset, then req at vpc 0x80000000 -> next cycle pred_valid_o=1, pred_sum_o=0, pred_taken_o=1, pred_history_o=0; s_ghr=0x0001.
- Send 20 updates for pc 0x100 with taken=1, mispredict=1, history=0 -> w0 reaches +20 and wi reaches -20. A request with s_ghr=0 then gives sum = 20 + 16*20 = 340, taken=1.
- Send 200 same-direction mispredict updates with W=8 -> weights saturate at +127/-128 with no wrap. Correct updates with |sum|=50 > THETA -> no weight change.
- Three predictions taken 1,1,0 (s_ghr=0b110), then a mispredict update with taken=1 from c_ghr=0 -> c_ghr=0x0001 and s_ghr=0x0001 at the same edge, overriding a coincident predict shift.
- flush_i with c_ghr=0x00A5, s_ghr=0x1234 -> s_ghr=0x00A5 next cycle; c_ghr is unchanged.
- debug_mode_i=1 with a mispredict update -> table, c_ghr and s_ghr are unchanged. Same-cycle predict and update at one index -> pred_sum_o reflects the old weights.
